// File: rtl/ddr3_param_issuer_if.sv
// Descriptor-word handshake and parameter-register broadcast bus for ddr3_param_issuer.
// Optional param_mask signal present only when DDR3_PARAM_MASK_EN is defined.
interface ddr3_param_issuer_if #(
    parameter int unsigned ADDR_WIDTH = 33
);
    logic                  start;
    logic                  word_valid;
    logic [ADDR_WIDTH-1:0] word_data;
    logic                  word_ready;
    logic [ADDR_WIDTH-1:0] params;
    logic [3:0]            input_param_id;
    logic [2:0]            output_param_id;
    logic                  busy;
    logic                  done;
`ifdef DDR3_PARAM_MASK_EN
    logic [14:0]           param_mask;

    modport master (
        output start, word_valid, word_data, param_mask,
        input  word_ready, params, input_param_id, output_param_id, busy, done
    );

    modport slave (
        input  start, word_valid, word_data, param_mask,
        output word_ready, params, input_param_id, output_param_id, busy, done
    );
`else
    modport master (
        output start, word_valid, word_data,
        input  word_ready, params, input_param_id, output_param_id, busy, done
    );

    modport slave (
        input  start, word_valid, word_data,
        output word_ready, params, input_param_id, output_param_id, busy, done
    );
`endif
endinterface

// File: rtl/ddr3_param_issuer.sv
// Streams one 15-word layer descriptor into the DDR3 parameter register file.
// Define DDR3_PARAM_MASK_EN to add a per-index enable mask sampled on start.
module ddr3_param_issuer #(
    parameter int unsigned ADDR_WIDTH = 33
) (
    input  logic               clk,
    input  logic               rst_n,
    ddr3_param_issuer_if.slave bus
);

    localparam int unsigned NUM_IDX = 15;
    localparam int unsigned NUM_IN  = 11;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned SRCH_W  = 5;
    localparam int unsigned IN_ID_W = 4;
    localparam int unsigned OUT_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_next;
    logic [SRCH_W-1:0]     hit;
    logic                  accept_c;

    logic [NUM_IDX-1:0]    mask_q;
    logic [NUM_IDX-1:0]    start_mask;

    logic [ADDR_WIDTH-1:0] params_q,   params_d;
    logic [IN_ID_W-1:0]    in_id_q,    in_id_d;
    logic [OUT_ID_W-1:0]   out_id_q,   out_id_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  ready_q,    ready_d;

    // Lowest enabled index at or above 'from'; NUM_IDX when none remains.
    function automatic logic [SRCH_W-1:0] find_next(input logic [NUM_IDX-1:0] m,
                                                   input logic [SRCH_W-1:0]  from);
        logic [SRCH_W-1:0] r;
        r = SRCH_W'(NUM_IDX);
        for (int k = NUM_IDX - 1; k >= 0; k--) begin
            if (m[k] && (SRCH_W'(k) >= from)) r = SRCH_W'(k);
        end
        return r;
    endfunction

`ifdef DDR3_PARAM_MASK_EN
    assign start_mask = bus.param_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mask_q <= '0;
        else if (state == IDLE && bus.start)
            mask_q <= bus.param_mask;
    end
`else
    assign start_mask = {NUM_IDX{1'b1}};
    assign mask_q     = {NUM_IDX{1'b1}};
`endif

    assign accept_c = (state == ISSUE) && bus.word_valid && ready_q;

    // State and index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state: skip disabled indices without spending a cycle on them.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        hit        = SRCH_W'(NUM_IDX);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    hit = find_next(start_mask, SRCH_W'(0));
                    if (hit == SRCH_W'(NUM_IDX)) begin
                        state_next = FINISH;
                        idx_next   = '0;
                    end else begin
                        state_next = ISSUE;
                        idx_next   = IDX_W'(hit);
                    end
                end
            end
            ISSUE: begin
                if (accept_c) begin
                    hit = find_next(mask_q, SRCH_W'(idx) + SRCH_W'(1));
                    if (hit == SRCH_W'(NUM_IDX)) begin
                        state_next = FINISH;
                        idx_next   = '0;
                    end else begin
                        idx_next   = IDX_W'(hit);
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
                idx_next   = '0;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Output decode: next values for the registered outputs.
    always_comb begin
        params_d = params_q;
        in_id_d  = '0;
        out_id_d = '0;
        done_d   = (state == FINISH);
        busy_d   = (state_next != IDLE) || (state == FINISH);
        ready_d  = (state_next == ISSUE);
        if (accept_c) begin
            params_d = bus.word_data;
            if (idx < IDX_W'(NUM_IN))
                in_id_d  = IN_ID_W'(idx) + IN_ID_W'(1);
            else
                out_id_d = OUT_ID_W'(idx - IDX_W'(NUM_IN)) + OUT_ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            params_q <= '0;
            in_id_q  <= '0;
            out_id_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            params_q <= params_d;
            in_id_q  <= in_id_d;
            out_id_q <= out_id_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.params          = params_q;
    assign bus.input_param_id  = in_id_q;
    assign bus.output_param_id = out_id_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.word_ready      = ready_q;

endmodule
